// File: rtl/alu_input_loader_pkg.sv
// Shared constants for the ALU input path: operand/op widths, button roles and debounce length.
// Consumed by alu_input_loader, its debouncer, the ALU and the board top.
// Also provides the debounce-counter width helper and the debouncer state type.
package alu_input_loader_pkg;

  localparam int unsigned NB_DATA_DEF         = 8;
  localparam int unsigned NB_OP_DEF           = 6;
  localparam int unsigned N_BUTTONS_DEF       = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;  // 10 ms at 100 MHz

  // Button roles (bit index into the button bus)
  localparam int unsigned BTN_A  = 0;
  localparam int unsigned BTN_B  = 1;
  localparam int unsigned BTN_OP = 2;

  typedef enum logic {
    DB_LOW  = 1'b0,
    DB_HIGH = 1'b1
  } db_state_e;

  // Counter must hold 0 .. n-1; one spare code keeps n = 1 at a legal width of 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/alu_input_loader_button_debouncer.sv
// button_debouncer: one pushbutton -> 2-FF sync -> optional debounce FSM -> single-cycle rise pulse.
// Ports: i_clk, i_rst_n (sync, active low), i_button (raw, async), o_pulse (registered strobe).
// Macro LOADER_DEBOUNCE_EN: defined -> LOW/HIGH FSM with stability counter; undefined -> sync value used directly.
module button_debouncer
  import alu_input_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_button,
  output logic o_pulse
);

  logic meta_q, sync_q;   // 2-FF synchronizer
  logic deb;              // debounced level
  logic prev_q;           // debounced level one cycle ago
  logic pulse_q, pulse_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_button;
      sync_q <= meta_q;
    end
  end

`ifdef LOADER_DEBOUNCE_EN
  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter only runs while the input disagrees with the accepted level;
  // any agreeing cycle restarts it, so a glitch must be fully stable to win.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= DB_LOW;
      cnt_q   <= '0;
    end else if (sync_q == state_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      state_q <= (state_q == DB_LOW) ? DB_HIGH : DB_LOW;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign deb = (state_q == DB_HIGH);
`else
  assign deb = sync_q;
`endif

  // Only LOW->HIGH of the accepted level produces a strobe; releases are silent.
  assign pulse_d = deb & ~prev_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= deb;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/alu_input_loader.sv
// alu_input_loader: syncs switches, debounces buttons, loads operand A/B and op code on button presses.
// Ports: i_clk, i_rst_n (sync, active low), i_sw, i_button -> o_data_a, o_data_b, o_op_code, o_load_pulse, o_valid.
// Macro LOADER_DEBOUNCE_EN selects debounced buttons (pulse at t+2+DEBOUNCE_CYCLES) vs. sync-only (pulse at t+2).
module alu_input_loader
  import alu_input_loader_pkg::*;
#(
  parameter int unsigned NB_DATA         = NB_DATA_DEF,
  parameter int unsigned NB_OP           = NB_OP_DEF,
  parameter int unsigned N_BUTTONS       = N_BUTTONS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NB_DATA-1:0]   i_sw,
  input  logic [N_BUTTONS-1:0] i_button,
  output logic [NB_DATA-1:0]   o_data_a,
  output logic [NB_DATA-1:0]   o_data_b,
  output logic [NB_OP-1:0]     o_op_code,
  output logic [N_BUTTONS-1:0] o_load_pulse,
  output logic                 o_valid
);

  logic [NB_DATA-1:0]   sw_meta_q, sw_sync_q;
  logic [N_BUTTONS-1:0] pulse;

  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [2:0]         loaded_q, loaded_d;  // {OP, B, A} loaded since reset
  logic               valid_q, valid_d;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_button(i_button[g]),
      .o_pulse (pulse[g])
    );
  end

  // Every target loads from the same synchronized word, so simultaneous presses agree.
  always_comb begin
    data_a_d = pulse[BTN_A]  ? sw_sync_q              : data_a_q;
    data_b_d = pulse[BTN_B]  ? sw_sync_q              : data_b_q;
    op_d     = pulse[BTN_OP] ? sw_sync_q[NB_OP-1:0]   : op_q;
    loaded_d = loaded_q | {pulse[BTN_OP], pulse[BTN_B], pulse[BTN_A]};
    valid_d  = &loaded_q;  // lags the last flag by one cycle
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      op_q      <= '0;
      loaded_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      sw_meta_q <= i_sw;
      sw_sync_q <= sw_meta_q;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      op_q      <= op_d;
      loaded_q  <= loaded_d;
      valid_q   <= valid_d;
    end
  end

  assign o_data_a     = data_a_q;
  assign o_data_b     = data_b_q;
  assign o_op_code    = op_q;
  assign o_load_pulse = pulse;
  assign o_valid      = valid_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// Directed bench for alu_input_loader with DEBOUNCE_CYCLES=4.
// Expected latencies follow LOADER_DEBOUNCE_EN: pulse at t+2+4 when defined, t+2 otherwise.
// Pulses are tallied per button by a negedge monitor; each scenario task checks its own results.
module tb_alu_input_loader;

  localparam int unsigned DEB = 4;
`ifdef LOADER_DEBOUNCE_EN
  localparam int LATP = DEB + 2;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LATP = 2;
  localparam bit DEB_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic [2:0] button;
  logic [7:0] data_a, data_b;
  logic [5:0] op_code;
  logic [2:0] load_pulse;
  logic       valid;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int pulse_cnt [3] = '{0, 0, 0};
  int pulse_cyc [3] = '{-1, -1, -1};

  alu_input_loader #(
    .NB_DATA(8), .NB_OP(6), .N_BUTTONS(3), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sw        (sw),
    .i_button    (button),
    .o_data_a    (data_a),
    .o_data_b    (data_b),
    .o_op_code   (op_code),
    .o_load_pulse(load_pulse),
    .o_valid     (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (load_pulse[i] === 1'b1) begin
        pulse_cnt[i] = pulse_cnt[i] + 1;
        pulse_cyc[i] = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw = 8'hFF; button = 3'b111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (load_pulse !== 3'b000) $display("FAIL reset_pulse cyc%0d got %b want 000", k, load_pulse);
      else n_pass++;
    end
    n_checks++; if (data_a  !== 8'h00) $display("FAIL reset_a got %h want 00", data_a);  else n_pass++;
    n_checks++; if (data_b  !== 8'h00) $display("FAIL reset_b got %h want 00", data_b);  else n_pass++;
    n_checks++; if (op_code !== 6'h00) $display("FAIL reset_op got %h want 00", op_code); else n_pass++;
    n_checks++; if (valid   !== 1'b0)  $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
    tick(1);
    button = 3'b000;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_clean_load();
    int t;
    int base;
    sw = 8'h3C; tick(3);
    base = pulse_cnt[0];
    button[0] = 1'b1;
    t = cyc + 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cyc == t + LATP) begin
        n_checks++;
        if (data_a !== 8'h00) $display("FAIL clean_a_early got %h want 00", data_a); else n_pass++;
      end
      if (cyc == t + LATP + 1) begin
        n_checks++;
        if (data_a !== 8'h3C) $display("FAIL clean_a_load got %h want 3c", data_a); else n_pass++;
      end
    end
    n_checks++; if (pulse_cnt[0] - base !== 1) $display("FAIL clean_pulse_count got %0d want 1", pulse_cnt[0] - base); else n_pass++;
    n_checks++; if (pulse_cyc[0] !== t + LATP) $display("FAIL clean_pulse_cycle got %0d want %0d", pulse_cyc[0], t + LATP); else n_pass++;
    n_checks++; if (data_b !== 8'h00) $display("FAIL clean_b_hold got %h want 00", data_b); else n_pass++;
    n_checks++; if (op_code !== 6'h00) $display("FAIL clean_op_hold got %h want 00", op_code); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL clean_valid got %b want 0", valid); else n_pass++;
    tick(1);
    button[0] = 1'b0;
    tick(DEB + 6);
  endtask

  task automatic test_bounce();
    int t;
    int base;
    sw = 8'h5A; tick(3);
    base = pulse_cnt[1];
    t = 0;
    // high 3 / low 1, four times, then stable high
    for (int i = 0; i < 16; i++) begin
      button[1] = (i % 4 != 3);
      tick(1);
    end
    button[1] = 1'b1;
    t = cyc + 1;
    tick(12);
    n_checks++;
    if (pulse_cnt[1] - base !== (DEB_ON ? 1 : 5))
      $display("FAIL bounce_press_count got %0d want %0d", pulse_cnt[1] - base, DEB_ON ? 1 : 5);
    else n_pass++;
    n_checks++; if (pulse_cyc[1] !== t + LATP) $display("FAIL bounce_pulse_cycle got %0d want %0d", pulse_cyc[1], t + LATP); else n_pass++;
    n_checks++; if (data_b !== 8'h5A) $display("FAIL bounce_b got %h want 5a", data_b); else n_pass++;
    n_checks++; if (data_a !== 8'h3C) $display("FAIL bounce_a_hold got %h want 3c", data_a); else n_pass++;
    // release: low 3 / high 1, four times, then stable low
    base = pulse_cnt[1];
    for (int i = 0; i < 16; i++) begin
      button[1] = (i % 4 == 3);
      tick(1);
    end
    button[1] = 1'b0;
    tick(12);
    n_checks++;
    if (pulse_cnt[1] - base !== (DEB_ON ? 0 : 4))
      $display("FAIL bounce_release_count got %0d want %0d", pulse_cnt[1] - base, DEB_ON ? 0 : 4);
    else n_pass++;
    n_checks++; if (data_b !== 8'h5A) $display("FAIL bounce_release_b got %h want 5a", data_b); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int t;
    sw = 8'hA5; tick(3);
    button = 3'b111;
    t = cyc + 1;
    for (int k = 0; k < LATP + 6; k++) begin
      @(negedge clk);
      if (cyc == t + LATP + 1) begin
        n_checks++; if (data_a !== 8'hA5) $display("FAIL simul_a got %h want a5", data_a); else n_pass++;
        n_checks++; if (data_b !== 8'hA5) $display("FAIL simul_b got %h want a5", data_b); else n_pass++;
        n_checks++; if (op_code !== 6'h25) $display("FAIL simul_op got %h want 25", op_code); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL simul_valid_early got %b want 0", valid); else n_pass++;
      end
      if (cyc == t + LATP + 2) begin
        n_checks++; if (valid !== 1'b1) $display("FAIL simul_valid got %b want 1", valid); else n_pass++;
      end
    end
    tick(1);
    button = 3'b000;
    tick(DEB + 6);
    n_checks++; if (valid !== 1'b1) $display("FAIL simul_valid_sticky got %b want 1", valid); else n_pass++;
  endtask

  task automatic test_short_press();
    int t;
    int base;
    sw = 8'h07; tick(3);
    base = pulse_cnt[0];
`ifdef LOADER_DEBOUNCE_EN
    // DEB-1 stable cycles: must be discarded
    button[0] = 1'b1; tick(DEB - 1);
    button[0] = 1'b0; tick(10);
    n_checks++; if (pulse_cnt[0] - base !== 0) $display("FAIL short_glitch_count got %0d want 0", pulse_cnt[0] - base); else n_pass++;
    n_checks++; if (data_a !== 8'hA5) $display("FAIL short_glitch_a got %h want a5", data_a); else n_pass++;
    // exactly DEB stable cycles: accepted
    button[0] = 1'b1; t = cyc + 1; tick(DEB);
    button[0] = 1'b0; tick(10);
`else
    button[0] = 1'b1; t = cyc + 1; tick(1);
    button[0] = 1'b0; tick(6);
`endif
    n_checks++; if (pulse_cnt[0] - base !== 1) $display("FAIL short_pulse_count got %0d want 1", pulse_cnt[0] - base); else n_pass++;
    n_checks++; if (pulse_cyc[0] !== t + LATP) $display("FAIL short_pulse_cycle got %0d want %0d", pulse_cyc[0], t + LATP); else n_pass++;
    n_checks++; if (data_a !== 8'h07) $display("FAIL short_a got %h want 07", data_a); else n_pass++;
  endtask

  task automatic test_reset_mid_debounce();
    int base;
    sw = 8'h3F; tick(3);
    base = pulse_cnt[2];
    button[2] = 1'b1; tick(2);
    rst_n = 1'b0; tick(3);
    button[2] = 1'b0; tick(1);
    rst_n = 1'b1; tick(LATP + 6);
    n_checks++; if (pulse_cnt[2] - base !== 0) $display("FAIL midrst_pulse got %0d want 0", pulse_cnt[2] - base); else n_pass++;
    n_checks++; if (op_code !== 6'h00) $display("FAIL midrst_op got %h want 00", op_code); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", valid); else n_pass++;
    n_checks++; if (data_a !== 8'h00) $display("FAIL midrst_a got %h want 00", data_a); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; sw = 8'h00; button = 3'b000;
    test_reset();
    test_clean_load();
    test_bounce();
    test_simultaneous();
    test_short_press();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
